// File: rtl/coax_rx_conditioner.sv
// Conditions the raw coax receiver pin for coax_buffered_rx: two-flop sync, majority
// glitch filter, self-transmit blanking with hold-off, TX->RX loopback and glitch stats.
module coax_rx_conditioner #(
  parameter int CLOCKS_PER_BIT = 16,
  parameter int FILTER_TAPS    = 3,
  parameter int HOLDOFF_BITS   = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_pin,
  input  logic       tx_active,
  input  logic       tx,
  input  logic       loopback,
  input  logic       enable,
  input  logic       glitch_clear,
  output logic       rx,
  output logic       blanked,
  output logic [7:0] glitch_count
);

  localparam int HOLD_CLKS = HOLDOFF_BITS * CLOCKS_PER_BIT;
  localparam int CNT_W     = (HOLD_CLKS > 1) ? $clog2(HOLD_CLKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CLKS - 1);
  localparam int SUM_W     = $clog2(FILTER_TAPS + 1);

  typedef enum logic [1:0] {
    ST_DISABLED,
    ST_PASS,
    ST_BLANK,
    ST_HOLDOFF
  } state_t;

  logic                   s0_reg;
  logic                   s1_reg;
  logic [FILTER_TAPS-1:0] taps_reg;
  logic [FILTER_TAPS-1:0] taps_next;
  logic                   filt_reg;
  logic [SUM_W-1:0]       ones;
  logic                   maj;
  logic                   glitch;
  state_t                 state_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   rx_reg;
  logic                   blanked_reg;
  logic                   loopback_reg;
  logic [7:0]             glitch_count_reg;

  // taps[0] holds the newest synchronised sample
  assign taps_next[0] = s1_reg;
  for (genvar gi = 1; gi < FILTER_TAPS; gi++) begin : g_tap
    assign taps_next[gi] = taps_reg[gi-1];
  end

  always_comb begin
    ones = '0;
    for (int i = 0; i < FILTER_TAPS; i++) begin
      ones = ones + SUM_W'(taps_reg[i]);
    end
    maj = (ones > SUM_W'(FILTER_TAPS / 2));
  end

  // A lone sample that disagrees with the filtered level and has just left the newest tap
  assign glitch = !loopback && (taps_reg[0] == filt_reg) && (taps_reg[1] != filt_reg)
                  && (maj == filt_reg);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0_reg   <= 1'b0;
      s1_reg   <= 1'b0;
      taps_reg <= '0;
      filt_reg <= 1'b0;
    end else begin
      s0_reg   <= rx_pin;
      s1_reg   <= s0_reg;
      taps_reg <= taps_next;
      filt_reg <= maj;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      glitch_count_reg <= 8'd0;
    end else if (glitch_clear) begin
      glitch_count_reg <= 8'd0;
    end else if (glitch && (glitch_count_reg != 8'hFF)) begin
      glitch_count_reg <= glitch_count_reg + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_DISABLED;
      cnt_reg      <= '0;
      rx_reg       <= 1'b0;
      blanked_reg  <= 1'b1;
      loopback_reg <= 1'b0;
    end else begin
      loopback_reg <= loopback;
      if (loopback) begin
        rx_reg      <= tx;
        blanked_reg <= 1'b0;
      end else if (loopback_reg) begin
        // Leaving loopback: the line may still carry our own echo, so hold off again
        state_reg   <= enable ? ST_HOLDOFF : ST_DISABLED;
        cnt_reg     <= CNT_LOAD;
        rx_reg      <= 1'b0;
        blanked_reg <= 1'b1;
      end else if (!enable) begin
        state_reg   <= ST_DISABLED;
        rx_reg      <= 1'b0;
        blanked_reg <= 1'b1;
      end else begin
        case (state_reg)
          ST_DISABLED: begin
            state_reg   <= ST_HOLDOFF;
            cnt_reg     <= CNT_LOAD;
            rx_reg      <= 1'b0;
            blanked_reg <= 1'b1;
          end
          ST_PASS: begin
            if (tx_active) begin
              state_reg   <= ST_BLANK;
              rx_reg      <= 1'b0;
              blanked_reg <= 1'b1;
            end else begin
              rx_reg      <= filt_reg;
              blanked_reg <= 1'b0;
            end
          end
          ST_BLANK: begin
            rx_reg      <= 1'b0;
            blanked_reg <= 1'b1;
            if (!tx_active) begin
              state_reg <= ST_HOLDOFF;
              cnt_reg   <= CNT_LOAD;
            end
          end
          ST_HOLDOFF: begin
            if (tx_active) begin
              state_reg   <= ST_BLANK;
              rx_reg      <= 1'b0;
              blanked_reg <= 1'b1;
            end else if (cnt_reg == '0) begin
              state_reg   <= ST_PASS;
              rx_reg      <= filt_reg;
              blanked_reg <= 1'b0;
            end else begin
              cnt_reg     <= cnt_reg - CNT_W'(1);
              rx_reg      <= 1'b0;
              blanked_reg <= 1'b1;
            end
          end
          default: begin
            state_reg   <= ST_DISABLED;
            rx_reg      <= 1'b0;
            blanked_reg <= 1'b1;
          end
        endcase
      end
    end
  end

  assign rx           = rx_reg;
  assign blanked      = blanked_reg;
  assign glitch_count = glitch_count_reg;

endmodule
